// File: rtl/inference_sequencer.sv
// Control sequencer for a two-layer digit classifier: bias load, pixel stream,
// layer-1 drain, layer-2 score scan with running argmax, and a completion pulse.
module inference_sequencer #(
   parameter int N_PIXELS   = 784,
   parameter int N_CLASSES  = 10,
   parameter int PIPE_DELAY = 8,
   parameter int SCORE_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic [3:0]                bias_addr,
   output logic [N_CLASSES-1:0]      bias_load,
   output logic [9:0]                pixel_addr,
   output logic                      pixel_valid,
   output logic [3:0]                layer1_addr,
   input  logic signed [SCORE_W-1:0] score_in,
   output logic [3:0]                digit,
   output logic                      done
);

   typedef enum logic [2:0] {
      IDLE,
      BIAS,
      PIXEL,
      DRAIN,
      SCORE,
      FLUSH,
      DONE
   } state_t;

   localparam int WAIT_W = (PIPE_DELAY > 2) ? $clog2(PIPE_DELAY) : 1;

   localparam logic [3:0]        BIAS_LAST  = 4'(N_CLASSES - 1);
   localparam logic [9:0]        PIX_LAST   = 10'(N_PIXELS - 1);
   localparam logic [3:0]        CLS_LAST   = 4'(N_CLASSES - 1);
   localparam logic [WAIT_W-1:0] DRAIN_LAST = WAIT_W'(PIPE_DELAY - 1);
   localparam logic [WAIT_W-1:0] FLUSH_LAST = WAIT_W'(1);

   state_t state, state_nxt;

   logic [WAIT_W-1:0] wait_cnt;
   logic [1:0]        pix_pipe;
   logic [1:0]        sc_vld;
   logic [3:0]        sc_idx0, sc_idx1;

   logic signed [SCORE_W-1:0] max_score;
   logic [3:0]                max_idx;
   logic                      have_max;
   logic                      take;
   logic [3:0]                idx_nxt;

   logic clear_run;

   assign clear_run = (state == IDLE) && start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      bias_load = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = BIAS;
         end
         BIAS: begin
            bias_load = N_CLASSES'(1) << bias_addr;
            if (bias_addr == BIAS_LAST) state_nxt = PIXEL;
         end
         PIXEL: if (pixel_addr == PIX_LAST)  state_nxt = DRAIN;
         DRAIN: if (wait_cnt == DRAIN_LAST)  state_nxt = SCORE;
         SCORE: if (layer1_addr == CLS_LAST) state_nxt = FLUSH;
         FLUSH: if (wait_cnt == FLUSH_LAST)  state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shared dwell counter for DRAIN and FLUSH, restarted on every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        wait_cnt <= '0;
      else if (state_nxt != state)                    wait_cnt <= '0;
      else if ((state == DRAIN) || (state == FLUSH))  wait_cnt <= wait_cnt + 1'b1;
   end

   // Address counters saturate at their last value and are only cleared on a new start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bias_addr   <= '0;
         pixel_addr  <= '0;
         layer1_addr <= '0;
      end else if (clear_run) begin
         bias_addr   <= '0;
         pixel_addr  <= '0;
         layer1_addr <= '0;
      end else begin
         if ((state == BIAS) && (bias_addr != BIAS_LAST))
            bias_addr <= bias_addr + 4'd1;
         if ((state == PIXEL) && (pixel_addr != PIX_LAST))
            pixel_addr <= pixel_addr + 10'd1;
         if ((state == SCORE) && (layer1_addr != CLS_LAST))
            layer1_addr <= layer1_addr + 4'd1;
      end
   end

   // Two-stage strobes matching the fixed ROM / score read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_pipe <= '0;
         sc_vld   <= '0;
         sc_idx0  <= '0;
         sc_idx1  <= '0;
      end else begin
         pix_pipe <= {pix_pipe[0], state == PIXEL};
         sc_vld   <= {sc_vld[0], state == SCORE};
         sc_idx0  <= layer1_addr;
         sc_idx1  <= sc_idx0;
      end
   end

   assign pixel_valid = pix_pipe[1];

   always_comb begin
      take    = sc_vld[1] && (!have_max || (score_in > max_score));
      idx_nxt = take ? sc_idx1 : max_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_score <= '0;
         max_idx   <= '0;
         have_max  <= 1'b0;
      end else if (clear_run) begin
         max_score <= '0;
         max_idx   <= '0;
         have_max  <= 1'b0;
      end else if (take) begin
         max_score <= score_in;
         max_idx   <= sc_idx1;
         have_max  <= 1'b1;
      end
   end

   // The final capture lands on the FLUSH->DONE edge, so digit takes the forwarded index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          digit <= '0;
      else if ((state == FLUSH) && (state_nxt == DONE)) digit <= idx_nxt;
   end

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: timing, streams, argmax and reset behaviour.
module tb_inference_sequencer;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              busy;
   logic [3:0]        bias_addr;
   logic [9:0]        bias_load;
   logic [9:0]        pixel_addr;
   logic              pixel_valid;
   logic [3:0]        layer1_addr;
   logic signed [15:0] score_in;
   logic [3:0]        digit;
   logic              done;

   logic signed [15:0] scores [0:15];
   logic [3:0]         a1, a2;
   logic [34:0]        all_out;

   int n_checks = 0;
   int n_fail   = 0;

   int   done_cyc, done_cyc2, done_cnt, nvalid, first_valid, busy_low_cyc;
   bit   bias_err, contig_err, busy_err;
   logic [3:0] dig_done, dig_pre, dig_end, la_end;
   logic [9:0] pa_end;
   logic [9:0] pa_arr [0:2047];

   always #5 clk = ~clk;

   // Score memory model: data follows layer1_addr by two cycles.
   always @(posedge clk) begin
      a1 <= layer1_addr;
      a2 <= a1;
   end
   assign score_in = scores[a2];

   assign all_out = {busy, bias_addr, bias_load, pixel_addr, pixel_valid,
                     layer1_addr, digit, done};

   inference_sequencer #(
      .N_PIXELS  (784),
      .N_CLASSES (10),
      .PIPE_DELAY(8),
      .SCORE_W   (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .bias_addr  (bias_addr),
      .bias_load  (bias_load),
      .pixel_addr (pixel_addr),
      .pixel_valid(pixel_valid),
      .layer1_addr(layer1_addr),
      .score_in   (score_in),
      .digit      (digit),
      .done       (done)
   );

   task automatic load_scores(input int v [10]);
      for (int i = 0; i < 16; i++) scores[i] = '0;
      for (int i = 0; i < 10; i++) scores[i] = 16'(v[i]);
   endtask

   // Pulse (or hold) start, then sample cycles 1..ncyc at the falling edge.
   task automatic go_and_watch(input int ncyc, input bit hold);
      done_cyc = -1; done_cyc2 = -1; done_cnt = 0; nvalid = 0;
      first_valid = -1; busy_low_cyc = -1;
      bias_err = 1'b0; contig_err = 1'b0; busy_err = 1'b0;
      dig_done = 'x; dig_pre = 'x; pa_end = 'x; la_end = 'x;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         pa_arr[c] = pixel_addr;
         if (busy !== (c <= 815)) busy_err = 1'b1;
         if (!busy && busy_low_cyc < 0) busy_low_cyc = c;
         if (c <= 800) begin
            if (c <= 10) begin
               if (bias_load !== 10'(1 << (c - 1)) || bias_addr !== 4'(c - 1)) bias_err = 1'b1;
            end else if (bias_load !== '0) bias_err = 1'b1;
         end
         if (pixel_valid) begin
            if (first_valid < 0) first_valid = c;
            if (c < 3) contig_err = 1'b1;
            else if (pa_arr[c-2] !== 10'(nvalid)) contig_err = 1'b1;
            nvalid++;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c;
               dig_done = digit;
               pa_end   = pixel_addr;
               la_end   = layer1_addr;
            end else if (done_cyc2 < 0) done_cyc2 = c;
         end
         if (c == 814) dig_pre = digit;
      end
      dig_end = digit;
      start = 1'b0;
   endtask

   task automatic test_reset;
      start = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      start = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_nominal;
      int v [10] = '{5, -3, 9, 2, 9, 0, 1, -8, 4, 7};
      load_scores(v);
      go_and_watch(830, 1'b0);
      n_checks++; if (done_cyc !== 815) begin n_fail++; $display("FAIL nom_done_cycle: got %0d want 815", done_cyc); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL nom_done_count: got %0d want 1", done_cnt); end
      n_checks++; if (dig_done !== 4'd2) begin n_fail++; $display("FAIL nom_digit: got %0d want 2", dig_done); end
      n_checks++; if (dig_end !== 4'd2) begin n_fail++; $display("FAIL nom_digit_hold: got %0d want 2", dig_end); end
      n_checks++; if (dig_pre !== 4'd0) begin n_fail++; $display("FAIL nom_digit_before_done: got %0d want 0", dig_pre); end
      n_checks++; if (busy_err) begin n_fail++; $display("FAIL nom_busy_window: got busy outside 1..815 want busy exactly 1..815"); end
      n_checks++; if (bias_err) begin n_fail++; $display("FAIL nom_bias_walk: got bad bias_load/bias_addr want 0x001..0x200 then 0"); end
      n_checks++; if (nvalid !== 784) begin n_fail++; $display("FAIL nom_valid_count: got %0d want 784", nvalid); end
      n_checks++; if (first_valid !== 13) begin n_fail++; $display("FAIL nom_first_valid: got %0d want 13", first_valid); end
      n_checks++; if (contig_err) begin n_fail++; $display("FAIL nom_pixel_contig: got non-contiguous want 0..783"); end
      n_checks++; if (pa_end !== 10'd783) begin n_fail++; $display("FAIL nom_pixel_end: got %0d want 783", pa_end); end
      n_checks++; if (la_end !== 4'd9) begin n_fail++; $display("FAIL nom_layer1_end: got %0d want 9", la_end); end
   endtask

   task automatic test_back_to_back;
      go_and_watch(1700, 1'b1);
      n_checks++; if (done_cyc !== 815) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 815", done_cyc); end
      n_checks++; if (busy_low_cyc !== 816) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d want 816", busy_low_cyc); end
      n_checks++; if (done_cyc2 !== 1631) begin n_fail++; $display("FAIL b2b_second_done: got %0d want 1631", done_cyc2); end
      n_checks++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (all_out !== '0) begin n_fail++; $display("FAIL b2b_reset_outputs: got %h want 0", all_out); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      bit found = 1'b0;
      bit bad = 1'b0;
      int v [10] = '{5, -3, 9, 2, 9, 0, 1, -8, 4, 7};
      load_scores(v);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (pixel_addr == 10'd400) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL mid_reach_400: got timeout want pixel_addr=400"); end
      rst = 1'b1;
      #1;
      n_checks++;
      if (all_out !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", all_out); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (all_out !== '0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL mid_reset_hold: got nonzero outputs want 0"); end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_release_idle: busy=%b done=%b want 0 0", busy, done); end
      go_and_watch(830, 1'b0);
      n_checks++; if (done_cyc !== 815) begin n_fail++; $display("FAIL mid_rerun_done: got %0d want 815", done_cyc); end
      n_checks++; if (nvalid !== 784) begin n_fail++; $display("FAIL mid_rerun_valid: got %0d want 784", nvalid); end
      n_checks++; if (dig_done !== 4'd2) begin n_fail++; $display("FAIL mid_rerun_digit: got %0d want 2", dig_done); end
      n_checks++; if (bias_err) begin n_fail++; $display("FAIL mid_rerun_bias: got bad bias walk want 0x001..0x200"); end
   endtask

   task automatic test_all_negative;
      int v [10] = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
      load_scores(v);
      go_and_watch(830, 1'b0);
      n_checks++; if (dig_pre !== 4'd2) begin n_fail++; $display("FAIL neg_digit_before_done: got %0d want 2", dig_pre); end
      n_checks++; if (dig_done !== 4'd0) begin n_fail++; $display("FAIL neg_digit: got %0d want 0", dig_done); end
      n_checks++; if (done_cyc !== 815) begin n_fail++; $display("FAIL neg_done_cycle: got %0d want 815", done_cyc); end
   endtask

   task automatic test_all_equal;
      int v [10] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
      load_scores(v);
      go_and_watch(830, 1'b0);
      n_checks++; if (dig_done !== 4'd0) begin n_fail++; $display("FAIL eq_digit: got %0d want 0", dig_done); end
   endtask

   task automatic test_signed_compare;
      int v [10] = '{-5, 3, 0, 0, 0, 0, 0, 0, 0, 0};
      load_scores(v);
      go_and_watch(830, 1'b0);
      n_checks++; if (dig_done !== 4'd1) begin n_fail++; $display("FAIL signed_digit: got %0d want 1", dig_done); end
   endtask

   task automatic test_last_max;
      int v [10] = '{0, 20, 0, 0, 0, 0, 0, 0, 0, 100};
      load_scores(v);
      go_and_watch(830, 1'b0);
      n_checks++; if (dig_done !== 4'd9) begin n_fail++; $display("FAIL last_digit: got %0d want 9", dig_done); end
      n_checks++; if (dig_end !== 4'd9) begin n_fail++; $display("FAIL last_digit_hold: got %0d want 9", dig_end); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) scores[i] = '0;
      test_reset;
      test_nominal;
      test_back_to_back;
      test_reset_mid;
      test_all_negative;
      test_all_equal;
      test_signed_compare;
      test_last_max;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): N_PIXELS, 784, pixels per image; N_CLASSES, 10, output classes; PIPE_DELAY, 8, layer-1 drain cycles; SCORE_W, 16, signed score width.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1; asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1; begins one inference when sampled high in IDLE.
REQ-005 SHALL have port busy, output, 1; high in every state except IDLE.
REQ-006 SHALL have port bias_addr, output, 4; bias ROM address.
REQ-007 SHALL have port bias_load, output, N_CLASSES; one-hot per-neuron bias load strobe.
REQ-008 SHALL have port pixel_addr, output, 10; pixel/weight ROM address.
REQ-009 SHALL have port pixel_valid, output, 1; MAC enable, aligned to ROM data.
REQ-010 SHALL have port layer1_addr, output, 4; layer-1 result select.
REQ-011 SHALL have port score_in, input, SCORE_W; signed layer-2 score, valid 2 cycles after its layer1_addr.
REQ-012 SHALL have port digit, output, 4; argmax class index.
REQ-013 SHALL have port done, output, 1; one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, BIAS, PIXEL, DRAIN, SCORE, FLUSH, DONE; one transition at most per clk.
REQ-015 IDLE: start=1 -> BIAS, all counters cleared, argmax state cleared; start=0 -> stay.
REQ-016 BIAS: 10 cycles, cycle k (0..9) drives bias_addr=k, bias_load=1<<k; after k=9 -> PIXEL; bias_load=0 outside BIAS.
REQ-017 PIXEL: N_PIXELS cycles, pixel_addr steps 0..N_PIXELS-1, one per cycle; after last address -> DRAIN.
REQ-018 pixel_valid SHALL equal the PIXEL-state read strobe delayed exactly 2 cycles (fixed ROM latency); exactly N_PIXELS valid cycles per inference.
REQ-019 DRAIN: PIPE_DELAY cycles, no new reads; then -> SCORE.
REQ-020 SCORE: N_CLASSES cycles, layer1_addr steps 0..N_CLASSES-1; after last -> FLUSH.
REQ-021 score capture strobe SHALL be the SCORE read strobe delayed 2 cycles, carrying the class index with it.
REQ-022 Argmax: first captured score initializes max and index; later scores replace only if strictly greater (signed compare); ties keep lowest index.
REQ-023 FLUSH: 2 cycles, for the last score capture; then -> DONE.
REQ-024 DONE: 1 cycle, done=1, digit updated to final argmax index; then -> IDLE.
REQ-025 digit SHALL hold its value until the next DONE; done high only in DONE.
REQ-026 start SHALL be ignored in all states except IDLE, including the DONE cycle.
REQ-027 Latency: start sampled at edge 0 -> done high in cycle 10+N_PIXELS+PIPE_DELAY+N_CLASSES+2+1 (815 at defaults).
REQ-028 Counters SHALL never wrap: pixel_addr ends at N_PIXELS-1, layer1_addr at N_CLASSES-1, and each holds its final value until IDLE clears it.

Reset
REQ-029 rst=1 at any time, including mid-inference, SHALL force IDLE and clear the delay pipelines and argmax state.
REQ-030 While rst=1, all outputs SHALL be 0: busy, bias_addr, bias_load, pixel_addr, pixel_valid, layer1_addr, digit, done.
REQ-031 The first edge after rst release SHALL evaluate the IDLE state.

Verification
REQ-032 Nominal: pulse start, scores {5,-3,9,2,9,0,1,-8,4,7} -> done at cycle 815, digit=2 (tie with 4 resolved low), busy high for cycles 1..815.
REQ-033 Pixel stream: count pixel_valid cycles -> exactly 784; first valid 2 cycles after pixel_addr=0; valid data addresses contiguous 0..783.
REQ-034 Bias: cycles 1..10 after start -> bias_load=0x001..0x200 walking, bias_addr 0..9, bias_load 0 afterwards.
REQ-035 Start while busy: start held high throughout -> single done, next inference starts only after return to IDLE.
REQ-036 Reset mid-PIXEL (pixel_addr=400): rst pulse -> all outputs 0, no done; a new start gives full 815-cycle run.
REQ-037 All-negative scores {-1..-10} -> digit=0; all equal (0x7FFF) -> digit=0.
